// File: rtl/multi_ball_renderer.sv
// Bouncing multi-ball renderer: per-frame position sweep plus per-pixel colour.
// Optional grey halo around balls when MULTI_BALL_SHADOW_EN is defined.
module multi_ball_renderer #(
   parameter int NUM_BALLS = 4,
   parameter int RADIUS    = 20,
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SPEED_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         hpos,
   input  logic [9:0]         vpos,
   input  logic               display_on,
   input  logic               frame_start,
   input  logic               pause,
   input  logic [SPEED_W-1:0] speed,
   output logic [5:0]         rgb,
   output logic [15:0]        bounce_cnt,
   output logic               busy
);

   localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam logic [10:0] XHI = 11'(H_ACTIVE - RADIUS);
   localparam logic [10:0] YHI = 11'(V_ACTIVE - RADIUS);
   localparam logic [10:0] LO  = 11'(RADIUS);
   localparam logic [24:0] RSQ = 25'(RADIUS * RADIUS);
`ifdef MULTI_BALL_SHADOW_EN
   localparam logic [24:0] RS2 = 25'((RADIUS + 4) * (RADIUS + 4));
`endif

   typedef enum logic {IDLE, UPDATE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx;
   logic [9:0]        bx [NUM_BALLS];
   logic [9:0]        by [NUM_BALLS];
   logic              bdx [NUM_BALLS];
   logic              bdy [NUM_BALLS];
   logic [10:0]       spd;
   logic [11:0]       sx, sy;
   logic [1:0]        flips;
   logic [16:0]       cnt_sum;
   logic [5:0]        pix;
   logic              hit;
   logic signed [23:0] ddx, ddy;
   logic [23:0]       px, py;
   logic [24:0]       d;
`ifdef MULTI_BALL_SHADOW_EN
   logic              shadow;
`endif

   // Returns {new_pos, new_dir, flipped} for one axis of one ball.
   function automatic logic [11:0] step_axis(input logic [9:0] pos,
                                             input logic dir,
                                             input logic [10:0] s,
                                             input logic [10:0] hi);
      logic [10:0] p, up, dn;
      logic [11:0] r;
      p  = {1'b0, pos};
      up = p + s;
      dn = p - s;
      r  = {pos, dir, 1'b0};
      if (s != '0) begin
         if (dir) begin
            if (up >= hi) r = {hi[9:0], 1'b0, 1'b1};
            else          r = {up[9:0], 1'b1, 1'b0};
         end else begin
            if (p <= LO + s) r = {LO[9:0], 1'b1, 1'b1};
            else             r = {dn[9:0], 1'b0, 1'b0};
         end
      end
      return r;
   endfunction

   function automatic logic [5:0] ball_colour(input int i);
      logic [1:0] k;
      logic [5:0] c;
      k = 2'(i);
      c = 6'b111000;
      unique case (k)
         2'd0: c = 6'b111000;
         2'd1: c = 6'b001111;
         2'd2: c = 6'b110011;
         2'd3: c = 6'b001100;
      endcase
      return c;
   endfunction

   assign busy = (state_q == UPDATE);
   assign spd  = 11'(speed);

   // Sweep FSM state and ball index register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx     <= '0;
      end else begin
         state_q <= state_d;
         idx     <= (state_q == UPDATE) ? idx + 1'b1 : '0;
      end
   end

   // Next-state: start on an unpaused frame pulse, end after the last ball.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (frame_start && !pause) state_d = UPDATE;
         UPDATE: if (idx == IW'(NUM_BALLS - 1)) state_d = IDLE;
      endcase
   end

   // Motion step for the ball currently selected by the sweep.
   always_comb begin
      sx      = step_axis(bx[idx], bdx[idx], spd, XHI);
      sy      = step_axis(by[idx], bdy[idx], spd, YHI);
      flips   = {1'b0, sx[0]} + {1'b0, sy[0]};
      cnt_sum = {1'b0, bounce_cnt} + 17'(flips);
   end

   // Ball state: initial layout on reset, one ball rewritten per sweep cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            bx[i]  <= 10'(160 + 64 * i);
            by[i]  <= 10'(120 + 32 * i);
            bdx[i] <= ((i % 2) == 0);
            bdy[i] <= 1'b1;
         end
      end else if (state_q == UPDATE) begin
         bx[idx]  <= sx[11:2];
         bdx[idx] <= sx[1];
         by[idx]  <= sy[11:2];
         bdy[idx] <= sy[1];
      end
   end

   // Saturating wall-bounce counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                bounce_cnt <= '0;
      else if (state_q == UPDATE) bounce_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   // Pixel colour: lowest-index core wins, then halo, then background.
   always_comb begin
      pix = 6'b000010;
      hit = 1'b0;
      ddx = '0;
      ddy = '0;
      px  = '0;
      py  = '0;
      d   = '0;
`ifdef MULTI_BALL_SHADOW_EN
      shadow = 1'b0;
`endif
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
         ddx = $signed({14'd0, hpos}) - $signed({14'd0, bx[i]});
         ddy = $signed({14'd0, vpos}) - $signed({14'd0, by[i]});
         px  = ddx * ddx;
         py  = ddy * ddy;
         d   = {1'b0, px} + {1'b0, py};
         if (d <= RSQ) begin
            hit = 1'b1;
            pix = ball_colour(i);
         end
`ifdef MULTI_BALL_SHADOW_EN
         if (d <= RS2) shadow = 1'b1;
`endif
      end
`ifdef MULTI_BALL_SHADOW_EN
      if (shadow && !hit) pix = 6'b010101;
`endif
   end

   // Registered video output, blanked outside the active area.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb <= '0;
      else        rgb <= display_on ? pix : 6'b000000;
   end

endmodule
